// File: rtl/disp_scan_driver.sv
// rtl/disp_scan_driver.sv - switch debounce to cn1 select, disdata capture, 8-digit 7-seg scan
module disp_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] sw,
    output logic [10:0] cn1,
    input  logic [31:0] disdata,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

    logic [10:0]      sync1;
    logic [10:0]      sync2;
    logic [10:0]      candidate;
    logic [DEB_W-1:0] deb_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // One counter covers all 11 switches: any bit change restarts the whole vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            deb_cnt   <= '0;
            cn1       <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                deb_cnt   <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                cn1 <= candidate;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Shadow loads only on the 7->0 wrap so every frame shows one coherent word.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            shadow  <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) begin
                shadow <= disdata;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h01 << idx);
            seg <= hex7(shadow[4*idx +: 4]);
            dp  <= !((idx == 3'd0) && (cn1[10:9] != 2'b00));
        end
    end

endmodule

// File: tb/tb_disp_scan_driver.sv
// tb/tb_disp_scan_driver.sv - directed self-checking bench for disp_scan_driver
module tb_disp_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] sw;
    logic [10:0] cn1;
    logic [31:0] disdata;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_cn1 = '0;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    disp_scan_driver #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .cn1     (cn1),
        .disdata (disdata),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered at the first cycle of digit 0; leaves at the first cycle of the next frame.
    task automatic frame(input logic [31:0] shown, input int chg_idx, input logic [31:0] chg_val);
        logic [7:0] e_an;
        logic [3:0] nib;
        for (int i = 0; i < 8; i++) begin
            e_an = ~(8'h01 << i);
            nib  = shown[4*i +: 4];
            check($sformatf("an_d%0d", i), {24'h0, an}, {24'h0, e_an});
            check($sformatf("seg_d%0d", i), {25'h0, seg}, {25'h0, HEX[nib]});
            check($sformatf("dp_d%0d", i), {31'h0, dp},
                  {31'h0, !((i == 0) && (exp_cn1[10:9] != 2'b00))});
            if (i == chg_idx) disdata = chg_val;
            tick(4);
        end
    endtask

    initial begin
        reset   = 1'b1;
        sw      = 11'h000;
        disdata = 32'h1234ABCD;
        tick(3);
        check("rst_an", {24'h0, an}, 32'hFF);
        check("rst_seg", {25'h0, seg}, 32'h7F);
        check("rst_dp", {31'h0, dp}, 32'h1);
        check("rst_cn1", {21'h0, cn1}, 32'h0);

        reset = 1'b0;
        tick(1);
        frame(32'h0, -1, 32'h0);
        frame(32'h1234ABCD, 7, 32'h12345678);
        frame(32'h12345678, 3, 32'h87654321);
        frame(32'h87654321, -1, 32'h0);

        sw = 11'h401;
        tick(10);
        check("deb_early", {21'h0, cn1}, 32'h000);
        tick(1);
        check("deb_edge", {21'h0, cn1}, 32'h401);
        exp_cn1 = 11'h401;
        sw = 11'h400;
        tick(5);
        sw = 11'h401;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            check("deb_glitch", {21'h0, cn1}, 32'h401);
        end
        tick(1);
        frame(32'h87654321, -1, 32'h0);

        sw = 11'h201;
        frame(32'h87654321, -1, 32'h0);
        exp_cn1 = 11'h201;
        check("cn1_201", {21'h0, cn1}, 32'h201);
        frame(32'h87654321, -1, 32'h0);
        sw = 11'h000;
        frame(32'h87654321, -1, 32'h0);
        exp_cn1 = 11'h000;
        check("cn1_000", {21'h0, cn1}, 32'h000);
        frame(32'h87654321, -1, 32'h0);

        tick(15);
        sw = 11'h7FF;
        tick(6);
        check("mid_an_d5", {24'h0, an}, 32'hDF);
        reset = 1'b1;
        tick(1);
        check("mid_rst_an", {24'h0, an}, 32'hFF);
        check("mid_rst_seg", {25'h0, seg}, 32'h7F);
        check("mid_rst_dp", {31'h0, dp}, 32'h1);
        check("mid_rst_cn1", {21'h0, cn1}, 32'h0);
        reset = 1'b0;
        tick(1);
        check("restart_an0", {24'h0, an}, 32'hFE);
        check("restart_seg0", {25'h0, seg}, 32'h40);
        tick(3);
        check("restart_an0_hold", {24'h0, an}, 32'hFE);
        tick(1);
        check("restart_an1", {24'h0, an}, 32'hFD);
        tick(5);
        check("restart_cn1_early", {21'h0, cn1}, 32'h000);
        tick(1);
        check("restart_cn1", {21'h0, cn1}, 32'h7FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_driver.md
Name: disp_scan_driver

Overview:
- Board-side consumer of the CPU debug display interface.
- Debounces the 11 raw selector switches into the registered cn1 select word the CPU top consumes.
- Captures the 32-bit disdata word the CPU returns for that select.
- Time-multiplexes the word as 8 hex digits onto a common-anode 7-segment display.
- Sits between the board pins and the CPU top, alongside the instruction/data memories.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is held (>=1)
DEBOUNCE, 1000000, cycles the synchronised switch vector must be stable before cn1 updates (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sw  input  11  raw asynchronous slide switches
cn1  output  11  debounced select word to CPU; [10:9]=source, [8:0]=sub-select
disdata  input  32  word selected by cn1, from CPU
an  output  8  digit enables, active-low, one-hot; an[i] drives digit i (digit 0 rightmost)
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
Reset:
- Synchronous, active-high (sampled on rising clk).
- All of the following take their reset values in the same edge, including mid-scan and mid-debounce:
  - cn1=0, an=8'hFF (all off), seg=7'h7F, dp=1.
  - Scan divider=0, digit index=0, shadow word=0.
  - Debounce counter=0, candidate=0, synchroniser flops=0.

Synchroniser:
- sw passes through 2 flops before any use.
- Raw-to-synced latency is 2 cycles.

Debounce:
- One shared counter covers the whole 11-bit vector.
- If synced != candidate: candidate<=synced and counter<=0.
- Else the counter increments, saturating at DEBOUNCE-1.
- In a cycle where counter==DEBOUNCE-1 and synced==candidate: cn1<=candidate.
- A change in any bit restarts the count for all bits.
- Glitches shorter than DEBOUNCE cycles never reach cn1.
- A stable change reaches cn1 exactly 2+1+DEBOUNCE cycles after the raw edge.

Scan divider:
- Counts 0..SCAN_DIV-1.
- At terminal count: divider<=0 and digit index<=index+1 (mod 8, 7 wraps to 0).
- SCAN_DIV=1 advances the index every cycle.

Shadow capture:
- In the cycle index wraps 7->0, shadow<=disdata.
- All 8 digits of one frame therefore come from one coherent sample; disdata changes mid-frame are not shown until the next frame.
- No other load condition.

Output register (1 cycle after index/shadow):
- an<=~(8'b1<<index).
- seg<=hex7(shadow[4*index+3 : 4*index]).
- dp<=0 iff index==0 and cn1[10:9]!=2'b00, else 1.

hex7 (active-low, {g..a}):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).

Invariants:
- Exactly one an bit is low at all times after the first post-reset cycle.
- No blank or overlap cycle occurs between digits.

Test Plan:
1. Reset, SCAN_DIV=4: hold reset 3 cycles -> an=FF, seg=7F, dp=1, cn1=000. After release, an steps FE,FD,FB,...,7F every 4 cycles, then wraps to FE.
2. disdata=32'h1234ABCD, SCAN_DIV=4, from reset -> first frame shows all digits 0 (seg=40). From the second frame, digit0..7 segs = 21,46,03,08,19,30,24,79.
3. Coherence: change disdata from 12345678 to 87654321 while index=3 -> the remaining digits of that frame still show 1234 nibbles. The next frame shows 87654321.
4. Debounce, DEBOUNCE=8: sw 000->401 stable -> cn1=401 exactly 11 cycles after the raw edge. Then sw toggles bit0 for 5 cycles and back -> cn1 stays 401.
5. dp: cn1[10:9]=01 -> dp=0 only while an=FE. cn1[10:9]=00 -> dp=1 always.
6. Reset mid-operation at index=5, counter mid-count -> next cycle all outputs at reset values. The scan restarts at index 0 with a 4-cycle hold.
